// File: rtl/pla_prog_eval.sv
// Runtime-programmable two-level AND/OR evaluator with a 2-stage valid/ready pipeline.
// Each result carries the number of product terms that matched the input vector.
module pla_prog_eval #(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned N_OUT   = 7,
  parameter int unsigned N_TERMS = 16,
  localparam int unsigned AW     = $clog2(N_TERMS + 1),
  localparam int unsigned CW     = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  output logic             cfg_ready,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [N_IN-1:0]  cfg_care,
  input  logic [N_IN-1:0]  cfg_val,
  input  logic [N_OUT-1:0] cfg_or,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_z,
  output logic [CW-1:0]    out_nhit
);

  logic [N_IN-1:0]    care  [N_TERMS];
  logic [N_IN-1:0]    val   [N_TERMS];
  logic [N_OUT-1:0]   or_pl [N_TERMS];
  logic [N_OUT-1:0]   inv;

  logic               s1_valid;
  logic [N_TERMS-1:0] s1_hit;
  logic               s2_valid;

  logic               cfg_fire;
  logic               s2_load;
  logic               s1_adv;
  logic               in_fire;
  logic [N_TERMS-1:0] hit;
  logic [N_OUT-1:0]   z_c;
  logic [CW-1:0]      nhit_c;

  // Handshake: config only lands on an empty pipeline and then blocks input for that cycle.
  always_comb begin
    cfg_ready = ~s1_valid & ~s2_valid;
    cfg_fire  = cfg_we & cfg_ready;
    s2_load   = ~s2_valid | out_ready;
    s1_adv    = s1_valid & s2_load;
    in_ready  = (~s1_valid | s1_adv) & ~cfg_fire;
    in_fire   = in_valid & in_ready;
  end

  // AND plane: a term matches when every cared literal equals its required value.
  always_comb begin
    hit = '0;
    for (int t = 0; t < int'(N_TERMS); t++) begin
      hit[t] = &(~care[t] | ~(in_x ^ val[t]));
    end
  end

  // OR plane, output polarity and hit count, evaluated from the stage-1 hit vector.
  always_comb begin
    z_c    = '0;
    nhit_c = '0;
    for (int j = 0; j < int'(N_OUT); j++) begin
      for (int t = 0; t < int'(N_TERMS); t++) begin
        z_c[j] = z_c[j] | (s1_hit[t] & or_pl[t][j]);
      end
    end
    z_c = z_c ^ inv;
    for (int t = 0; t < int'(N_TERMS); t++) begin
      nhit_c = nhit_c + CW'(s1_hit[t]);
    end
  end

  // Term table and invert mask; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < int'(N_TERMS); t++) begin
        care[t]  <= '0;
        val[t]   <= '0;
        or_pl[t] <= '0;
      end
      inv <= '0;
    end else if (cfg_fire) begin
      if (cfg_addr == AW'(N_TERMS)) begin
        inv <= cfg_or;
      end else begin
        for (int t = 0; t < int'(N_TERMS); t++) begin
          if (cfg_addr == AW'(t)) begin
            care[t]  <= cfg_care;
            val[t]   <= cfg_val;
            or_pl[t] <= cfg_or;
          end
        end
      end
    end
  end

  // Stage 1: capture the hit vector of an accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_hit   <= hit;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result register; holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_z    <= '0;
      out_nhit <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_z    <= z_c;
        out_nhit <= nhit_c;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule
